// File: rtl/stream_mux_pkg.sv
// Shared types for the N:1 stream multiplexer: channel-selection mode and
// round-robin packet-lock state.
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } rr_state_e;

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Combinational rotating-priority search: the first requesting channel
// strictly after ptr (with wrap) wins; ptr itself has the lowest priority.
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] ptr,
    output logic [NUM_CH-1:0]         grant,
    output logic [$clog2(NUM_CH)-1:0] idx,
    output logic                      any
);
    localparam int SEL_W = $clog2(NUM_CH);

    int               cand;
    logic [SEL_W-1:0] cand_idx;

    // Walk from the farthest offset down so the nearest requester is written last.
    always_comb begin
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_idx = SEL_W'(cand);
            if (req[cand_idx]) begin
                idx = cand_idx;
                any = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_grant
            assign grant[gi] = any && (idx == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/stream_mux_nto1.sv
// N:1 valid/ready stream multiplexer with one registered output stage.
// Channel is chosen by a fixed software select or packet-aware round-robin.
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode_i,
    input  logic [$clog2(NUM_CH)-1:0] sel_i,
    input  logic [NUM_CH-1:0]         in_valid_i,
    input  logic [NUM_CH*WIDTH-1:0]   in_data_i,
    input  logic [NUM_CH-1:0]         in_last_i,
    output logic [NUM_CH-1:0]         in_ready_o,
    output logic                      out_valid_o,
    output logic [WIDTH-1:0]          out_data_o,
    output logic                      out_last_o,
    output logic [$clog2(NUM_CH)-1:0] out_ch_o,
    input  logic                      out_ready_i
);
    localparam int SEL_W = $clog2(NUM_CH);

    mux_mode_e        mode;
    rr_state_e        state_reg;
    logic [SEL_W-1:0] rr_ptr_reg;
    logic [SEL_W-1:0] lock_ch_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_last_reg;
    logic [SEL_W-1:0] out_ch_reg;

    logic [NUM_CH-1:0] arb_grant;
    logic [SEL_W-1:0]  arb_idx;
    logic              arb_any;

    logic              slot_free;
    logic              grant_valid;
    logic [SEL_W-1:0]  grant_idx;
    logic [NUM_CH-1:0] grant_oh;
    logic [WIDTH-1:0]  ch_data [NUM_CH];
    logic [WIDTH-1:0]  sel_data;
    logic              sel_last;
    logic              accept;

    assign mode      = mux_mode_e'(mode_i);
    assign slot_free = !out_valid_reg || out_ready_i;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .req   (in_valid_i),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // A locked channel keeps the grant even while its valid is low.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (mode == MODE_FIXED) begin
            grant_idx   = sel_i;
            grant_valid = int'(sel_i) < NUM_CH;
        end else if (state_reg == ST_LOCKED) begin
            grant_idx   = lock_ch_reg;
            grant_valid = 1'b1;
        end else begin
            grant_idx   = arb_idx;
            grant_valid = arb_any;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign grant_oh[gi]   = grant_valid && (grant_idx == SEL_W'(gi));
            assign in_ready_o[gi] = grant_oh[gi] && slot_free;
            assign ch_data[gi]    = in_data_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_oh[i]) begin
                sel_data = ch_data[i];
                sel_last = in_last_i[i];
            end
        end
    end

    assign accept = |(in_valid_i & in_ready_o);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_ch_reg    <= '0;
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= SEL_W'(NUM_CH - 1);
            lock_ch_reg   <= '0;
        end else begin
            // A new beat may replace one draining in the same cycle.
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= sel_data;
                out_last_reg  <= sel_last;
                out_ch_reg    <= grant_idx;
            end else if (out_ready_i) begin
                out_valid_reg <= 1'b0;
            end

            if (mode == MODE_FIXED) begin
                state_reg <= ST_IDLE;
            end else if (accept) begin
                rr_ptr_reg <= grant_idx;
                case (state_reg)
                    ST_IDLE: begin
                        if (!sel_last) begin
                            state_reg   <= ST_LOCKED;
                            lock_ch_reg <= grant_idx;
                        end
                    end
                    ST_LOCKED: begin
                        if (sel_last) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign out_valid_o = out_valid_reg;
    assign out_data_o  = out_data_reg;
    assign out_last_o  = out_last_reg;
    assign out_ch_o    = out_ch_reg;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed bench for stream_mux_nto1: a 4-channel instance for most scenarios
// and a 5-channel instance for the out-of-range select case.
module tb_stream_mux_nto1;

    logic        clk;
    logic        reset;

    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic        mode5;
    logic [2:0]  sel5;
    logic [4:0]  in_valid5;
    logic [39:0] in_data5;
    logic [4:0]  in_last5;
    logic [4:0]  in_ready5;
    logic        out_valid5;
    logic [7:0]  out_data5;
    logic        out_last5;
    logic [2:0]  out_ch5;
    logic        out_ready5;

    int n_cmp;
    int n_err;

    stream_mux_nto1 #(.NUM_CH(4), .WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_i      (mode),
        .sel_i       (sel),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_ch_o    (out_ch),
        .out_ready_i (out_ready)
    );

    stream_mux_nto1 #(.NUM_CH(5), .WIDTH(8)) dut5 (
        .clk         (clk),
        .reset       (reset),
        .mode_i      (mode5),
        .sel_i       (sel5),
        .in_valid_i  (in_valid5),
        .in_data_i   (in_data5),
        .in_last_i   (in_last5),
        .in_ready_o  (in_ready5),
        .out_valid_o (out_valid5),
        .out_data_o  (out_data5),
        .out_last_o  (out_last5),
        .out_ch_o    (out_ch5),
        .out_ready_i (out_ready5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        mode = 1'b0; sel = 2'd0; in_valid = 4'h0; in_last = 4'h0;
        in_data = 32'hA3A2A1A0; out_ready = 1'b1;
        mode5 = 1'b0; sel5 = 3'd0; in_valid5 = 5'h0; in_last5 = 5'h0;
        in_data5 = 40'hB4B3B2B1B0; out_ready5 = 1'b1;
        reset = 1'b1;
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", out_last); end
        n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL reset_ch: got %0d want 0", out_ch); end
        n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL reset_ready: got %b want 0001", in_ready); end
        n_cmp++; if (out_valid5 !== 1'b0) begin n_err++; $display("FAIL reset_valid5: got %b want 0", out_valid5); end
        @(posedge clk); #1;
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_fixed();
        reset_dut();
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_last = 4'h0;
        in_data = 32'hA3A2A1A0; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL fixed_ready0: got %b want 0100", in_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fixed_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (out_data !== 8'hA2) begin n_err++; $display("FAIL fixed_data[%0d]: got %h want a2", i, out_data); end
            n_cmp++; if (out_ch !== 2'd2) begin n_err++; $display("FAIL fixed_ch[%0d]: got %0d want 2", i, out_ch); end
            n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL fixed_ready[%0d]: got %b want 0100", i, in_ready); end
            $display("fixed beat %0d: ch=%0d data=%h", i, out_ch, out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
        reset_dut();
        mode = 1'b0; sel = 2'd0; in_valid = 4'hF; in_last = 4'h0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data[7:0] = seq[i];
            tick();
            n_cmp++; if (out_data !== seq[i]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_data, seq[i]); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
            $display("b2b beat %0d: data=%h", i, out_data);
        end
        in_data[7:0] = 8'hA0;
    endtask

    task automatic test_rr();
        logic [1:0] exp_ch [5]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] exp_data [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        reset_dut();
        mode = 1'b1; in_valid = 4'hF; in_last = 4'hF; in_data = 32'hA3A2A1A0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (out_ch !== exp_ch[i]) begin n_err++; $display("FAIL rr_ch[%0d]: got %0d want %0d", i, out_ch, exp_ch[i]); end
            n_cmp++; if (out_data !== exp_data[i]) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", i, out_data, exp_data[i]); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b want 1", i, out_valid); end
            $display("rr beat %0d: ch=%0d data=%h", i, out_ch, out_data);
        end
    endtask

    task automatic test_packet_lock();
        logic [1:0] exp_ch [5]   = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
        logic [7:0] exp_data [5] = '{8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA2};
        logic       exp_last [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        reset_dut();
        mode = 1'b1; in_valid = 4'b0111; in_last = 4'b0101; in_data = 32'hA3A2A1A0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (out_ch !== exp_ch[i]) begin n_err++; $display("FAIL lock_ch[%0d]: got %0d want %0d", i, out_ch, exp_ch[i]); end
            n_cmp++; if (out_data !== exp_data[i]) begin n_err++; $display("FAIL lock_data[%0d]: got %h want %h", i, out_data, exp_data[i]); end
            n_cmp++; if (out_last !== exp_last[i]) begin n_err++; $display("FAIL lock_last[%0d]: got %b want %b", i, out_last, exp_last[i]); end
            if (i == 1 || i == 2) begin
                n_cmp++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL lock_ready[%0d]: got %b want 0010", i, in_ready); end
            end
            $display("lock beat %0d: ch=%0d last=%b", i, out_ch, out_last);
            in_last[1] = (i == 2);
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_last = 4'h0;
        in_data = 32'hA3A255A0; out_ready = 1'b1;
        tick();
        n_cmp++; if (out_data !== 8'h55) begin n_err++; $display("FAIL bp_first: got %h want 55", out_data); end
        out_ready = 1'b0;
        in_data = 32'hA3A266A0;
        #1;
        n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready0: got %b want 0000", in_ready); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (out_data !== 8'h55) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %h want 55", i, out_data); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_hold_ready[%0d]: got %b want 0000", i, in_ready); end
            $display("bp stall %0d: data=%h ready=%b", i, out_data, in_ready);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready: got %b want 0010", in_ready); end
        tick();
        n_cmp++; if (out_data !== 8'h66) begin n_err++; $display("FAIL bp_next: got %h want 66", out_data); end
        $display("bp release: data=%h", out_data);
    endtask

    task automatic test_sel_range();
        reset_dut();
        mode5 = 1'b0; sel5 = 3'd4; in_valid5 = 5'h1F; in_last5 = 5'h0;
        in_data5 = 40'hB4B3B2B1B0; out_ready5 = 1'b1;
        #1;
        n_cmp++; if (in_ready5 !== 5'b10000) begin n_err++; $display("FAIL sel4_ready: got %b want 10000", in_ready5); end
        tick();
        n_cmp++; if (out_data5 !== 8'hB4) begin n_err++; $display("FAIL sel4_data: got %h want b4", out_data5); end
        n_cmp++; if (out_ch5 !== 3'd4) begin n_err++; $display("FAIL sel4_ch: got %0d want 4", out_ch5); end
        sel5 = 3'd5;
        #1;
        n_cmp++; if (in_ready5 !== 5'b00000) begin n_err++; $display("FAIL sel5_ready: got %b want 00000", in_ready5); end
        tick();
        n_cmp++; if (out_valid5 !== 1'b0) begin n_err++; $display("FAIL sel5_drain: got %b want 0", out_valid5); end
        sel5 = 3'd7;
        #1;
        n_cmp++; if (in_ready5 !== 5'b00000) begin n_err++; $display("FAIL sel7_ready: got %b want 00000", in_ready5); end
        $display("sel range: valid5=%b ready5=%b", out_valid5, in_ready5);
    endtask

    task automatic test_reset_locked();
        reset_dut();
        mode = 1'b1; in_valid = 4'b0100; in_last = 4'h0; in_data = 32'hA3A2A1A0; out_ready = 1'b1;
        tick();
        n_cmp++; if (out_ch !== 2'd2 || out_valid !== 1'b1) begin n_err++; $display("FAIL rl_lock: got ch=%0d v=%b want ch=2 v=1", out_ch, out_valid); end
        n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL rl_ready: got %b want 0100", in_ready); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rl_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rl_data: got %h want 00", out_data); end
        n_cmp++; if (out_ch !== 2'd0 || out_last !== 1'b0) begin n_err++; $display("FAIL rl_ch_last: got ch=%0d l=%b want 0 0", out_ch, out_last); end
        tick();
        reset = 1'b0;
        in_valid = 4'hF; in_last = 4'hF;
        tick();
        n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL rl_first_grant: got %0d want 0", out_ch); end
        n_cmp++; if (out_data !== 8'hA0) begin n_err++; $display("FAIL rl_first_data: got %h want a0", out_data); end
        $display("reset locked: first ch=%0d", out_ch);
    endtask

    task automatic test_mode_switch();
        reset_dut();
        mode = 1'b1; in_valid = 4'b0100; in_last = 4'h0; in_data = 32'hA3A2A1A0; out_ready = 1'b1;
        tick();
        n_cmp++; if (out_ch !== 2'd2) begin n_err++; $display("FAIL ms_lock: got %0d want 2", out_ch); end
        mode = 1'b0; sel = 2'd0; in_valid = 4'hF;
        tick();
        n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL ms_fixed: got %0d want 0", out_ch); end
        mode = 1'b1; in_last = 4'hF;
        tick();
        n_cmp++; if (out_ch !== 2'd3) begin n_err++; $display("FAIL ms_rr1: got %0d want 3", out_ch); end
        tick();
        n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL ms_rr2: got %0d want 0", out_ch); end
        $display("mode switch: last ch=%0d", out_ch);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fixed();
        test_back_to_back();
        test_rr();
        test_packet_lock();
        test_backpressure();
        test_sel_range();
        test_reset_locked();
        test_mode_switch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
